// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

   localparam int unsigned BYTE_W             = 8;
   localparam int unsigned WORD_W             = 32;
   localparam int unsigned LEN_W              = 16;
   localparam int unsigned BYTES_PER_WORD     = WORD_W / BYTE_W;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
   localparam bit          BYTE_ORDER_LE      = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_LEN_HI = 3'd3,
      ST_DATA   = 3'd4,
      ST_WRITE  = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERROR  = 3'd7
   } state_t;

endpackage

// File: rtl/instr_loader_word_packer.sv
// Assembles four streamed bytes into one instruction word.
module word_packer
   import instr_loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              word_full_c,
   output logic [WORD_W-1:0] word_c
);

   localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  lane_c;
   logic [WORD_W-1:0] word_q;

   // word_c already contains the byte being pushed this cycle
   always_comb begin
      lane_c      = BYTE_ORDER_LE ? idx : (IDX_W'(BYTES_PER_WORD - 1) - idx);
      word_full_c = push && (idx == IDX_W'(BYTES_PER_WORD - 1));
      word_c      = word_q;
      if (push) begin
         word_c[BYTE_W*lane_c +: BYTE_W] = byte_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx    <= '0;
         word_q <= '0;
      end else if (clear) begin
         idx    <= '0;
         word_q <= '0;
      end else if (push) begin
         idx    <= idx + IDX_W'(1);
         word_q <= word_c;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed program into IF instruction memory, holding the core in reset until done.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned PC_SIZE        = 10,
   parameter int unsigned ADDR_STEP      = 1,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_start,
   input  logic               byte_valid,
   input  logic [BYTE_W-1:0]  byte_data,
   output logic               byte_ready,
   output logic               rw,
   output logic               reset_IF_memory,
   output logic [PC_SIZE-1:0] PC_write,
   output logic [WORD_W-1:0]  instruction_in,
   output logic               core_reset,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int unsigned MAX_WORDS = (1 << PC_SIZE) / ADDR_STEP;
   localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t             state, state_next;
   logic [BYTE_W-1:0]  len_lo;
   logic [LEN_W-1:0]   words_left;
   logic [CNT_W-1:0]   idle_cnt;
   logic               accept_c;
   logic               timeout_c;
   logic               counting_c;
   logic [LEN_W-1:0]   len_c;
   logic               pk_clear_c;
   logic               pk_push_c;
   logic               word_full_c;
   logic [WORD_W-1:0]  word_c;

   word_packer u_packer (
      .clock       (clock),
      .reset       (reset),
      .clear       (pk_clear_c),
      .push        (pk_push_c),
      .byte_data   (byte_data),
      .word_full_c (word_full_c),
      .word_c      (word_c)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next state; an accepted byte always wins over a timeout in the same cycle
   always_comb begin
      state_next = state;
      accept_c   = byte_valid && byte_ready;
      len_c      = {byte_data, len_lo};
      counting_c = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
      timeout_c  = (TIMEOUT_CYCLES != 0) && (32'(idle_cnt) == TIMEOUT_CYCLES);
      pk_clear_c = (state != ST_DATA);
      pk_push_c  = 1'b0;
      case (state)
         ST_IDLE:   if (load_start) state_next = ST_CLEAR;
         ST_CLEAR:  state_next = ST_LEN_LO;
         ST_LEN_LO: begin
            if (accept_c)       state_next = ST_LEN_HI;
            else if (timeout_c) state_next = ST_ERROR;
         end
         ST_LEN_HI: begin
            if (accept_c) begin
               if ((len_c == '0) || (32'(len_c) > MAX_WORDS)) state_next = ST_ERROR;
               else                                           state_next = ST_DATA;
            end else if (timeout_c) begin
               state_next = ST_ERROR;
            end
         end
         ST_DATA: begin
            if (accept_c) begin
               pk_push_c = 1'b1;
               if (word_full_c) state_next = ST_WRITE;
            end else if (timeout_c) begin
               state_next = ST_ERROR;
            end
         end
         ST_WRITE:  state_next = (words_left == LEN_W'(1)) ? ST_DONE : ST_DATA;
         ST_DONE:   if (load_start) state_next = ST_CLEAR;
         ST_ERROR:  if (load_start) state_next = ST_CLEAR;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track the state register exactly
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_ready      <= 1'b0;
         rw              <= 1'b0;
         reset_IF_memory <= 1'b0;
         core_reset      <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         byte_ready      <= state_next inside {ST_LEN_LO, ST_LEN_HI, ST_DATA};
         rw              <= (state_next == ST_WRITE);
         reset_IF_memory <= (state_next == ST_CLEAR);
         core_reset      <= (state_next != ST_DONE);
         busy            <= state_next inside {ST_CLEAR, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE};
         done            <= (state_next == ST_DONE);
         error           <= (state_next == ST_ERROR);
      end
   end

   // Length capture, address/word counters and the idle timer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         len_lo         <= '0;
         words_left     <= '0;
         PC_write       <= '0;
         instruction_in <= '0;
         idle_cnt       <= '0;
      end else begin
         if ((state == ST_LEN_LO) && accept_c) len_lo <= byte_data;
         if ((state == ST_LEN_HI) && accept_c) words_left <= len_c;
         else if (state == ST_WRITE)           words_left <= words_left - LEN_W'(1);
         if (state == ST_CLEAR)      PC_write <= '0;
         else if (state == ST_WRITE) PC_write <= PC_write + PC_SIZE'(ADDR_STEP);
         if ((state == ST_DATA) && word_full_c) instruction_in <= word_c;
         if (counting_c && !accept_c && (TIMEOUT_CYCLES != 0)) idle_cnt <= idle_cnt + CNT_W'(1);
         else                                                  idle_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes queued at stimulus time, checked on rw.
module tb_instr_loader;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, rw, reset_IF_memory, core_reset, busy, done, error;
   logic [7:0]  PC_write;
   logic [31:0] instruction_in;

   int checks = 0;
   int errors = 0;
   int clr_cnt = 0;
   int rw_cnt = 0;
   exp_t exp_q[$];

   instr_loader #(.PC_SIZE(8), .ADDR_STEP(1), .TIMEOUT_CYCLES(8)) dut (
      .clock           (clock),
      .reset           (reset),
      .load_start      (load_start),
      .byte_valid      (byte_valid),
      .byte_data       (byte_data),
      .byte_ready      (byte_ready),
      .rw              (rw),
      .reset_IF_memory (reset_IF_memory),
      .PC_write        (PC_write),
      .instruction_in  (instruction_in),
      .core_reset      (core_reset),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   always #5 clock = ~clock;

   // Write monitor: every rw pulse must match the head of the expectation queue
   always @(negedge clock) begin
      if (!reset) begin
         if (reset_IF_memory) clr_cnt++;
         if (rw) begin
            exp_t e;
            rw_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr=%0h data=%08h with nothing expected", PC_write, instruction_in);
            end else begin
               e = exp_q.pop_front();
               if ({PC_write, instruction_in} !== {e.addr, e.data}) begin
                  errors++;
                  $display("FAIL write: got %0h@%0h, want %08h@%0h", instruction_in, PC_write, e.data, e.addr);
               end
            end
            checks++;
            if (reset_IF_memory !== 1'b0) begin
               errors++;
               $display("FAIL rw_with_clear: reset_IF_memory=%b during rw, want 0", reset_IF_memory);
            end
         end
      end
   end

   task automatic pulse_start();
      @(negedge clock);
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      @(negedge clock);
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         errors++;
         $display("FAIL byte_ready_wait: byte_ready=%b after %0d cycles, want 1", byte_ready, n);
      end
      @(posedge clock);
      #1 byte_valid = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   task automatic send_stream(input logic [7:0] bytes[$], input int gap);
      foreach (bytes[i]) send_byte(bytes[i], gap);
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done || error) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if ({byte_ready, rw, reset_IF_memory, core_reset, busy, done, error} !== 7'b0001000) begin
         errors++;
         $display("FAIL reset_flags: got %b, want 0001000",
                  {byte_ready, rw, reset_IF_memory, core_reset, busy, done, error});
      end
      checks++;
      if ({PC_write, instruction_in} !== 40'h0) begin
         errors++;
         $display("FAIL reset_data: got %0h/%08h, want 0/00000000", PC_write, instruction_in);
      end
      reset = 1'b0;
   endtask

   task automatic finish_load(input string name, input int clr0, input int rw0, input int nw);
      bit ok;
      wait_end(40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_timeout: done/error never rose", name);
      end
      checks++;
      if ({done, error, core_reset, busy} !== 4'b1000) begin
         errors++;
         $display("FAIL %s_flags: done,error,core_reset,busy=%b want 1000", name, {done, error, core_reset, busy});
      end
      checks++;
      if (clr_cnt - clr0 != 1) begin
         errors++;
         $display("FAIL %s_clear_pulses: got %0d, want 1", name, clr_cnt - clr0);
      end
      checks++;
      if (rw_cnt - rw0 != nw || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_writes: got %0d left %0d, want %0d left 0", name, rw_cnt - rw0, exp_q.size(), nw);
      end
   endtask

   task automatic test_basic_load();
      int clr0 = clr_cnt;
      int rw0 = rw_cnt;
      exp_q.push_back('{addr: 8'd0, data: 32'h00100013});
      exp_q.push_back('{addr: 8'd1, data: 32'h00200093});
      pulse_start();
      send_stream('{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00}, 0);
      pulse_start();
      send_stream('{8'h93, 8'h00, 8'h20, 8'h00}, 0);
      finish_load("basic", clr0, rw0, 2);
   endtask

   task automatic test_toggled_valid();
      int clr0 = clr_cnt;
      int rw0 = rw_cnt;
      exp_q.push_back('{addr: 8'd0, data: 32'h00100013});
      exp_q.push_back('{addr: 8'd1, data: 32'h00200093});
      pulse_start();
      checks++;
      if ({core_reset, busy, reset_IF_memory} !== 3'b111) begin
         errors++;
         $display("FAIL restart_flags: core_reset,busy,clr=%b want 111", {core_reset, busy, reset_IF_memory});
      end
      send_stream('{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00}, 1);
      finish_load("toggled", clr0, rw0, 2);
   endtask

   task automatic test_bad_length();
      logic [15:0] lens[3] = '{16'h0000, 16'h0401, 16'h0101};
      bit ok;
      int rw0 = rw_cnt;
      foreach (lens[i]) begin
         pulse_start();
         send_stream('{lens[i][7:0], lens[i][15:8]}, 0);
         wait_end(10, ok);
         checks++;
         if (!ok || {error, done, core_reset, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL bad_len_%04h: error,done,core_reset,busy=%b want 1010", lens[i],
                     {error, done, core_reset, busy});
         end
      end
      checks++;
      if (rw_cnt != rw0) begin
         errors++;
         $display("FAIL bad_len_rw: got %0d writes, want 0", rw_cnt - rw0);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int rw0 = rw_cnt;
      pulse_start();
      send_stream('{8'h01, 8'h00, 8'h13, 8'h00}, 0);
      repeat (8) @(negedge clock);
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: error=%b after 8 idle cycles, want 0", error);
      end
      wait_end(10, ok);
      checks++;
      if (!ok || {error, done, core_reset} !== 3'b101) begin
         errors++;
         $display("FAIL timeout_error: error,done,core_reset=%b want 101", {error, done, core_reset});
      end
      checks++;
      if (rw_cnt != rw0) begin
         errors++;
         $display("FAIL timeout_rw: got %0d writes, want 0", rw_cnt - rw0);
      end
   endtask

   task automatic test_reset_mid_load();
      int clr0;
      int rw0;
      pulse_start();
      send_stream('{8'h00, 8'h01}, 0);
      @(negedge clock);
      checks++;
      if ({busy, error, byte_ready} !== 3'b101) begin
         errors++;
         $display("FAIL max_len_accept: busy,error,byte_ready=%b want 101", {busy, error, byte_ready});
      end
      exp_q.push_back('{addr: 8'd0, data: 32'hDEADBEEF});
      send_stream('{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11, 8'h22}, 0);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({byte_ready, rw, reset_IF_memory, core_reset, busy, done, error} !== 7'b0001000 ||
          {PC_write, instruction_in} !== 40'h0) begin
         errors++;
         $display("FAIL async_reset: flags=%b pc=%0h instr=%08h want 0001000/0/0",
                  {byte_ready, rw, reset_IF_memory, core_reset, busy, done, error}, PC_write, instruction_in);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pre_reset_write: %0d writes outstanding, want 0", exp_q.size());
      end
      @(negedge clock);
      reset = 1'b0;
      clr0 = clr_cnt;
      rw0 = rw_cnt;
      exp_q.push_back('{addr: 8'd0, data: 32'h00500513});
      pulse_start();
      send_stream('{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00}, 0);
      finish_load("reload", clr0, rw0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_load();
      test_toggled_valid();
      test_bad_length();
      test_timeout();
      test_reset_mid_load();
      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
